// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter slice.
//   arb_state_t      : arbiter FSM state encoding
//   host_idx_bits(n) : width of the host_sel_o index bus for n hosts
//   DefNrHosts/DefMaxLock : default parameter values
package bus_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

   localparam int unsigned DefNrHosts = 3;
   localparam int unsigned DefMaxLock = 4;

   // One extra bit beyond the minimal index width.
   function automatic int unsigned host_idx_bits(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   : request vector, one bit per host
//   ptr_i   : host index where the search starts (highest priority)
//   gnt_o   : one-hot grant, all zero when nothing requests
//   idx_o   : index of the granted host, 0 when nothing requests
//   valid_o : some host was picked
module bus_rr_pick #(
   parameter int unsigned NrHosts = 3
) (
   input  logic [NrHosts-1:0]         req_i,
   input  logic [$clog2(NrHosts)-1:0] ptr_i,
   output logic [NrHosts-1:0]         gnt_o,
   output logic [$clog2(NrHosts)-1:0] idx_o,
   output logic                       valid_o
);

   localparam int unsigned IdxW = $clog2(NrHosts);

   logic            w_found;
   int unsigned     w_cand;
   logic [IdxW-1:0] w_cand_idx;

   always_comb begin
      gnt_o      = '0;
      idx_o      = '0;
      w_found    = 1'b0;
      w_cand     = 0;
      w_cand_idx = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         // Candidate index walks ptr, ptr+1, ... modulo NrHosts.
         w_cand = 32'(ptr_i) + i;
         if (w_cand >= NrHosts) begin
            w_cand = w_cand - NrHosts;
         end
         w_cand_idx = IdxW'(w_cand);
         if (!w_found && req_i[w_cand_idx]) begin
            w_found           = 1'b1;
            gnt_o[w_cand_idx] = 1'b1;
            idx_o             = w_cand_idx;
         end
      end
      valid_o = w_found;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with optional bounded host locking.
// Build option: define BUS_ARB_LOCK_EN to include the lock feature; without it
// lock_i is ignored, locked_o is tied 0 and every grant advances the pointer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : per-host level-sensitive request
//   lock_i        : per-host request to keep ownership next cycle
//   gnt_o         : combinational one-hot grant
//   host_sel_o    : index of the granted host (0 when none)
//   valid_o       : any grant this cycle
//   rvalid_o      : registered copy of gnt_o, marks the response cycle
//   locked_o      : arbiter is in the LOCKED state
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned NrHosts = DefNrHosts,
   parameter int unsigned MaxLock = DefMaxLock
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NrHosts-1:0]                 req_i,
   input  logic [NrHosts-1:0]                 lock_i,
   output logic [NrHosts-1:0]                 gnt_o,
   output logic [host_idx_bits(NrHosts)-1:0]  host_sel_o,
   output logic                               valid_o,
   output logic [NrHosts-1:0]                 rvalid_o,
   output logic                               locked_o
);

   localparam int unsigned IdxW = $clog2(NrHosts);
   localparam int unsigned SelW = host_idx_bits(NrHosts);

   logic [IdxW-1:0]    r_ptr;
   logic [IdxW-1:0]    w_ptr_d;
   logic [NrHosts-1:0] r_rvalid;
   logic [NrHosts-1:0] w_gnt;
   logic [IdxW-1:0]    w_sel_idx;

   logic [NrHosts-1:0] w_rr_gnt;
   logic [IdxW-1:0]    w_rr_idx;
   logic               w_rr_valid;

   function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] v);
      if (32'(v) == NrHosts - 1) begin
         return '0;
      end
      return v + IdxW'(1);
   endfunction

   bus_rr_pick #(
      .NrHosts (NrHosts)
   ) u_rr_pick (
      .req_i   (req_i),
      .ptr_i   (r_ptr),
      .gnt_o   (w_rr_gnt),
      .idx_o   (w_rr_idx),
      .valid_o (w_rr_valid)
   );

`ifdef BUS_ARB_LOCK_EN
   localparam int unsigned CntW = $clog2(MaxLock + 1);

   arb_state_t      r_state;
   arb_state_t      w_state_d;
   logic [IdxW-1:0] r_owner;
   logic [IdxW-1:0] w_owner_d;
   logic [CntW-1:0] r_lock_cnt;
   logic [CntW-1:0] w_lock_cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ARB_IDLE;
         r_owner    <= '0;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_owner    <= w_owner_d;
         r_lock_cnt <= w_lock_cnt_d;
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_owner_d    = r_owner;
      w_lock_cnt_d = r_lock_cnt;
      w_ptr_d      = r_ptr;
      w_gnt        = '0;
      w_sel_idx    = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_rr_valid) begin
               w_gnt     = w_rr_gnt;
               w_sel_idx = w_rr_idx;
               if (lock_i[w_rr_idx]) begin
                  // Pointer stays put while locked; it moves on release.
                  w_state_d    = ARB_LOCKED;
                  w_owner_d    = w_rr_idx;
                  w_lock_cnt_d = CntW'(1);
               end else begin
                  w_ptr_d = inc_wrap(w_rr_idx);
               end
            end
         end
         ARB_LOCKED: begin
            if (req_i[r_owner]) begin
               w_gnt[r_owner] = 1'b1;
               w_sel_idx      = r_owner;
               if (!lock_i[r_owner] || r_lock_cnt == CntW'(MaxLock)) begin
                  w_state_d    = ARB_IDLE;
                  w_ptr_d      = inc_wrap(r_owner);
                  w_lock_cnt_d = '0;
               end else begin
                  w_lock_cnt_d = r_lock_cnt + CntW'(1);
               end
            end else begin
               // Owner walked away: no grant, releasing host goes last.
               w_state_d    = ARB_IDLE;
               w_ptr_d      = inc_wrap(r_owner);
               w_lock_cnt_d = '0;
            end
         end
         default: begin
            w_state_d = ARB_IDLE;
         end
      endcase
      if (!rst_ni) begin
         w_gnt     = '0;
         w_sel_idx = '0;
      end
   end

   assign locked_o = (r_state == ARB_LOCKED);
`else
   logic w_unused_lock;
   assign w_unused_lock = ^{lock_i, MaxLock[0]};

   always_comb begin
      w_ptr_d   = r_ptr;
      w_gnt     = w_rr_gnt;
      w_sel_idx = w_rr_idx;
      if (w_rr_valid) begin
         w_ptr_d = inc_wrap(w_rr_idx);
      end
      if (!rst_ni) begin
         w_gnt     = '0;
         w_sel_idx = '0;
      end
   end

   assign locked_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr    <= '0;
         r_rvalid <= '0;
      end else begin
         r_ptr    <= w_ptr_d;
         r_rvalid <= w_gnt;
      end
   end

   assign gnt_o      = w_gnt;
   assign host_sel_o = SelW'(w_sel_idx);
   assign valid_o    = |w_gnt;
   assign rvalid_o   = r_rvalid;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NrHosts=3, MaxLock=4). Expected values
// come from a behavioural model of the arbitration rules; lock behaviour is
// modelled only when BUS_ARB_LOCK_EN is defined.
module tb_bus_arbiter;

   localparam int unsigned N    = 3;
   localparam int unsigned MaxL = 4;
   localparam int unsigned SelW = 3;
   localparam int unsigned ObsW = 2 * N + SelW + 2;
`ifdef BUS_ARB_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N-1:0]    gnt;
   logic [SelW-1:0] sel;
   logic            valid;
   logic [N-1:0]    rvalid;
   logic            locked;

   int checks = 0;
   int errors = 0;

   // Model state
   int           m_ptr;
   int           m_owner;
   int           m_cnt;
   bit           m_locked;
   logic [N-1:0] m_rvalid;
   // Model predictions for the current cycle
   int              e_host;
   logic [N-1:0]    e_gnt;
   logic [SelW-1:0] e_sel;

   always #5 clk = ~clk;

   bus_arbiter #(
      .NrHosts (N),
      .MaxLock (MaxL)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .lock_i     (lock),
      .gnt_o      (gnt),
      .host_sel_o (sel),
      .valid_o    (valid),
      .rvalid_o   (rvalid),
      .locked_o   (locked)
   );

   task automatic model_reset();
      m_ptr    = 0;
      m_owner  = 0;
      m_cnt    = 0;
      m_locked = 1'b0;
      m_rvalid = '0;
   endtask

   // Drive inputs, let them settle, and predict this cycle's outputs.
   task automatic apply(input logic [N-1:0] r, input logic [N-1:0] l);
      req  = r;
      lock = l;
      #1;
      e_host = -1;
      if (rst_n) begin
         if (m_locked) begin
            if (r[m_owner]) e_host = m_owner;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (e_host < 0 && r[(m_ptr + k) % N]) e_host = (m_ptr + k) % N;
            end
         end
      end
      e_gnt = '0;
      e_sel = '0;
      if (e_host >= 0) begin
         e_gnt[e_host] = 1'b1;
         e_sel         = SelW'(e_host);
      end
   endtask

   // Clock edge: advance the model by the arbitration rules.
   task automatic advance();
      @(posedge clk);
      if (rst_n) begin
         m_rvalid = e_gnt;
         if (m_locked) begin
            if (req[m_owner] && lock[m_owner] && m_cnt < MaxL) begin
               m_cnt++;
            end else begin
               m_locked = 1'b0;
               m_ptr    = (m_owner + 1) % N;
               m_cnt    = 0;
            end
         end else if (e_host >= 0) begin
            if (LockEn && lock[e_host]) begin
               m_locked = 1'b1;
               m_owner  = e_host;
               m_cnt    = 1;
            end else begin
               m_ptr = (e_host + 1) % N;
            end
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [ObsW-1:0] exp_obs();
      return {e_gnt, e_sel, |e_gnt, m_rvalid, m_locked};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      apply('0, '0);
      advance();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      apply(3'b111, 3'b111);
      checks++;
      if (gnt !== '0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_gnt: gnt=%b valid=%b, want 000/0", gnt, valid);
      end
      checks++;
      if (locked !== 1'b0 || rvalid !== '0 || sel !== '0) begin
         errors++;
         $display("FAIL reset_state: locked=%b rvalid=%b sel=%0d, want 0/000/0",
                  locked, rvalid, sel);
      end
      advance();
      checks++;
      if (gnt !== '0 || rvalid !== '0) begin
         errors++;
         $display("FAIL reset_after_edge: gnt=%b rvalid=%b, want 000/000", gnt, rvalid);
      end
   endtask

   task automatic test_round_robin();
      int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         apply(3'b111, 3'b000);
         checks++;
         if ({gnt, sel, valid, rvalid, locked} !== exp_obs()) begin
            errors++;
            $display("FAIL rr_model c%0d: got %b want %b", i,
                     {gnt, sel, valid, rvalid, locked}, exp_obs());
         end
         checks++;
         if (int'(sel) !== exp_seq[i]) begin
            errors++;
            $display("FAIL rr_seq c%0d: host=%0d want %0d", i, sel, exp_seq[i]);
         end
         advance();
      end
   endtask

   task automatic test_single_host();
      for (int i = 0; i < 4; i++) begin
         apply(3'b010, 3'b000);
         checks++;
         if (gnt !== 3'b010 || sel !== SelW'(1)) begin
            errors++;
            $display("FAIL single_host c%0d: gnt=%b sel=%0d want 010/1", i, gnt, sel);
         end
         advance();
      end
      for (int i = 0; i < 2; i++) begin
         apply(3'b000, 3'b000);
         checks++;
         if ({gnt, sel, valid, rvalid, locked} !== exp_obs()) begin
            errors++;
            $display("FAIL idle_model c%0d: got %b want %b", i,
                     {gnt, sel, valid, rvalid, locked}, exp_obs());
         end
         advance();
      end
      // Pointer sat at host 2 across the idle cycles.
      apply(3'b111, 3'b000);
      checks++;
      if (sel !== SelW'(2) || gnt !== 3'b100) begin
         errors++;
         $display("FAIL ptr_hold: gnt=%b sel=%0d want 100/2", gnt, sel);
      end
      advance();
   endtask

   task automatic test_lock_max();
`ifdef BUS_ARB_LOCK_EN
      int exp_host[8] = '{0, 0, 0, 0, 0, 1, 2, 0};
      bit exp_lock[8] = '{0, 1, 1, 1, 1, 0, 0, 0};
`else
      int exp_host[8] = '{0, 1, 2, 0, 1, 2, 0, 1};
      bit exp_lock[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(3'b111, 3'b001);
         checks++;
         if (int'(sel) !== exp_host[i] || locked !== exp_lock[i] || valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_max c%0d: host=%0d locked=%b want %0d/%b", i, sel, locked,
                     exp_host[i], exp_lock[i]);
         end
         checks++;
         if ({gnt, sel, valid, rvalid, locked} !== exp_obs()) begin
            errors++;
            $display("FAIL lock_max_model c%0d: got %b want %b", i,
                     {gnt, sel, valid, rvalid, locked}, exp_obs());
         end
         advance();
      end
   endtask

   task automatic test_lock_release();
      logic [N-1:0] r_tab[5] = '{3'b100, 3'b101, 3'b101, 3'b101, 3'b101};
      logic [N-1:0] l_tab[5] = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
`ifdef BUS_ARB_LOCK_EN
      int exp_host[5] = '{2, 2, 2, 2, 0};
      bit exp_lock[5] = '{0, 1, 1, 1, 0};
`else
      int exp_host[5] = '{2, 0, 2, 0, 2};
      bit exp_lock[5] = '{0, 0, 0, 0, 0};
`endif
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(r_tab[i], l_tab[i]);
         checks++;
         if (int'(sel) !== exp_host[i] || locked !== exp_lock[i]) begin
            errors++;
            $display("FAIL lock_release c%0d: host=%0d locked=%b want %0d/%b", i, sel,
                     locked, exp_host[i], exp_lock[i]);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         apply(3'b001, 3'b001);
         advance();
      end
      apply(3'b001, 3'b001);
      checks++;
      if ({gnt, sel, valid, rvalid, locked} !== exp_obs()) begin
         errors++;
         $display("FAIL pre_abort_model: got %b want %b",
                  {gnt, sel, valid, rvalid, locked}, exp_obs());
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (gnt !== '0 || locked !== 1'b0 || rvalid !== '0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_lock: gnt=%b locked=%b rvalid=%b want 000/0/000",
                  gnt, locked, rvalid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(3'b111, 3'b000);
      checks++;
      if (sel !== '0 || gnt !== 3'b001) begin
         errors++;
         $display("FAIL post_abort_prio: gnt=%b sel=%0d want 001/0", gnt, sel);
      end
      advance();
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [N-1:0] l;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r = N'($urandom_range(0, 7));
         l = ($urandom_range(0, 3) != 0) ? r : N'($urandom_range(0, 7));
         apply(r, l);
         checks++;
         if ({gnt, sel, valid, rvalid, locked} !== exp_obs() || !$onehot0(gnt)) begin
            errors++;
            $display("FAIL random c%0d req=%b lock=%b: got %b want %b", i, r, l,
                     {gnt, sel, valid, rvalid, locked}, exp_obs());
         end
         advance();
         if ($urandom_range(0, 99) == 0) do_reset();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      lock  = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_single_host();
      test_lock_max();
      test_lock_release();
      test_reset_mid_lock();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
